// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op encodings, widths and FSM states.
package alu_pkg;

    localparam int ALU_OP_W       = 2;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!any_valid && req[idx]) begin
                any_valid     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters with round-robin
// arbitration, registered ALU operands and a registered valid/ready response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [ALU_OP_W-1:0]         alu_op,
    input  logic [DATA_W-1:0]           alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDX_W-1:0]            rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_zero
);

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_valid;
    logic                 handshake;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [ALU_OP_W-1:0]  sel_op;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Ready is gated by rst_n so nothing can be accepted while reset is held.
    assign handshake = rst_n && (state == ST_IDLE) && any_valid;
    assign req_ready = handshake ? grant_oh : '0;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (handshake) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_RESP;
            ST_RESP:  if (rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operand registers hold their last values between transactions on purpose.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= ALU_OP_ADD;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (handshake) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_op <= sel_op;
                rsp_id <= grant_idx;
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ST_ISSUE) begin
                rsp_data  <= alu_result;
                rsp_zero  <= (alu_result == '0);
                rsp_valid <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a stub ALU and a transaction-level
// reference model of arbitration order and ALU results.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DATA_W-1:0]   req_a;
    logic [NUM_REQ*DATA_W-1:0]   req_b;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;
    logic [DATA_W-1:0]           alu_a;
    logic [DATA_W-1:0]           alu_b;
    logic [ALU_OP_W-1:0]         alu_op;
    logic [DATA_W-1:0]           alu_result;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [0:0]                  rsp_id;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_zero;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   id_log[$];
    int   errors = 0;
    int   checks = 0;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    // Stub of the shared ALU that sits beside the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_OP_ADD: alu_result = alu_a + alu_b;
            ALU_OP_SUB: alu_result = alu_a + ~alu_b + 32'd1;
            ALU_OP_AND: alu_result = alu_a & alu_b;
            default:    alu_result = alu_a | alu_b;
        endcase
    end

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0001;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic valid);
        req_valid[id]                 = valid;
        req_a[id*DATA_W +: DATA_W]    = a;
        req_b[id*DATA_W +: DATA_W]    = b;
        req_op[id*ALU_OP_W +: ALU_OP_W] = op;
    endtask

    // Transaction-level model: whenever the block is free it must grant the first
    // valid requester at or after the rotating pointer; expectations go to exp_q.
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [31:0] last_a  = '0;
    logic [31:0] last_b  = '0;
    logic [1:0]  last_op = '0;

    always @(negedge clk) begin : model
        int                 g;
        logic [NUM_REQ-1:0] exp_ready;
        logic [31:0]        r;
        exp_t               e;
        if (!rst_n) begin
            checkOutput("reset_req_ready", 32'(req_ready), 0);
            exp_q.delete();
            m_phase = 0;
            m_ptr   = 0;
            last_a  = '0;
            last_b  = '0;
            last_op = '0;
        end else begin
            case (m_phase)
                0: begin
                    g = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                    end
                    exp_ready = '0;
                    if (g >= 0) exp_ready[g] = 1'b1;
                    checkOutput("idle_req_ready", 32'(req_ready), 32'(exp_ready));
                    checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
                    checkOutput("idle_alu_a_hold", alu_a, last_a);
                    checkOutput("idle_alu_op_hold", 32'(alu_op), 32'(last_op));
                    if (g >= 0) begin
                        last_a  = req_a[g*DATA_W +: DATA_W];
                        last_b  = req_b[g*DATA_W +: DATA_W];
                        last_op = req_op[g*ALU_OP_W +: ALU_OP_W];
                        r       = ref_alu(last_a, last_b, last_op);
                        e.id    = g;
                        e.data  = r;
                        e.zero  = (r == 32'd0);
                        exp_q.push_back(e);
                        m_ptr   = (g + 1) % NUM_REQ;
                        m_phase = 1;
                    end
                end
                1: begin
                    checkOutput("issue_req_ready", 32'(req_ready), 0);
                    checkOutput("issue_rsp_valid", 32'(rsp_valid), 0);
                    checkOutput("issue_alu_a", alu_a, last_a);
                    checkOutput("issue_alu_b", alu_b, last_b);
                    checkOutput("issue_alu_op", 32'(alu_op), 32'(last_op));
                    m_phase = 2;
                end
                default: begin
                    checkOutput("resp_rsp_valid", 32'(rsp_valid), 1);
                    checkOutput("resp_req_ready", 32'(req_ready), 0);
                    if (rsp_ready) m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp_unexpected: got rsp_valid=1, expected no pending response at %0t", $time);
            end else begin
                e = exp_q[0];
                checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    id_log.push_back(int'(rsp_id));
                end
            end
        end
    end

    task automatic runOp(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_data, input logic exp_zero);
        bit found = 1'b0;
        applyStimulus(id, a, b, op, 1'b1);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (req_ready[id]) found = 1'b1;
        end
        checkOutput("op_handshake", 32'(found), 1);
        @(posedge clk); #1;
        applyStimulus(id, a, b, op, 1'b0);
        @(negedge clk);
        checkOutput("op_latency_n1", 32'(rsp_valid), 0);
        @(negedge clk);
        checkOutput("op_latency_n2", 32'(rsp_valid), 1);
        checkOutput("op_data", rsp_data, exp_data);
        checkOutput("op_zero", 32'(rsp_zero), 32'(exp_zero));
        checkOutput("op_id", 32'(rsp_id), 32'(id));
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        logic [31:0] held;
        bit          found;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_alu_op", 32'(alu_op), 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_alu_b", alu_b, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_zero", 32'(rsp_zero), 0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ptr_grant0", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        runOp(0, 32'd1, 32'd3, ALU_OP_ADD, 32'd4, 1'b0);
        runOp(1, 32'd1, 32'd3, ALU_OP_SUB, 32'hFFFF_FFFE, 1'b0);
        runOp(0, 32'hF0, 32'h3C, ALU_OP_AND, 32'h30, 1'b0);
        runOp(0, 32'hF0, 32'h0F, ALU_OP_OR, 32'hFF, 1'b0);
        runOp(1, 32'd5, 32'd5, ALU_OP_SUB, 32'd0, 1'b1);

        id_log.delete();
        req_valid = 2'b11;
        for (int c = 0; c < 13; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                applyStimulus(i, pick_operand(), pick_operand(), 2'($urandom_range(0, 3)), 1'b1);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("contention_count", 32'(id_log.size() >= 4), 1);
        for (int k = 0; k < 4 && k < id_log.size(); k++) begin
            checkOutput("contention_order", 32'(id_log[k]), 32'(k % 2));
        end

        rsp_ready = 1'b0;
        applyStimulus(0, 32'h1234_5678, 32'h0000_0078, ALU_OP_SUB, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (req_ready[0]) found = 1'b1;
        end
        checkOutput("bp_handshake", 32'(found), 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
        held = rsp_data;
        checkOutput("bp_rsp_data", held, 32'h1234_5600);
        @(posedge clk); #1;
        applyStimulus(1, 32'd10, 32'd20, ALU_OP_ADD, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", rsp_data, held);
            checkOutput("bp_hold_valid", 32'(rsp_valid), 1);
            checkOutput("bp_no_ready", 32'(req_ready), 0);
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("bp_next_accept", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        applyStimulus(0, 32'd9, 32'd9, ALU_OP_ADD, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (req_ready[0]) found = 1'b1;
        end
        checkOutput("rst_mid_handshake", 32'(found), 1);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        runOp(1, 32'd7, 32'd8, ALU_OP_ADD, 32'd15, 1'b0);

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                logic [31:0] a;
                logic [31:0] b;
                a = pick_operand();
                b = ($urandom_range(0, 4) == 0) ? a : pick_operand();
                applyStimulus(i, a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion by 1ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
